// File: rtl/traffic_light_fsm.sv
// Intersection controller: main/side lamps, walk lamp, latched ped request.
// Steps once per clk_div rising edge, detected in the clk domain.
module traffic_light_fsm #(
  parameter int GREEN_TICKS  = 5,
  parameter int YELLOW_TICKS = 2,
  parameter int ALLRED_TICKS = 1,
  parameter int WALK_TICKS   = 4
) (
  input  logic       clk,
  input  logic       rst_a,
  input  logic       clk_div,
  input  logic       ped_req,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic [2:0] state,
  output logic       tick,
  output logic       ped_pend
);

  typedef enum logic [2:0] {
    S_MG   = 3'd0,
    S_MY   = 3'd1,
    S_AR1  = 3'd2,
    S_SG   = 3'd3,
    S_SY   = 3'd4,
    S_AR2  = 3'd5,
    S_WALK = 3'd6
  } state_e;

  localparam logic [7:0] G_LAST = 8'(GREEN_TICKS - 1);
  localparam logic [7:0] Y_LAST = 8'(YELLOW_TICKS - 1);
  localparam logic [7:0] A_LAST = 8'(ALLRED_TICKS - 1);
  localparam logic [7:0] W_LAST = 8'(WALK_TICKS - 1);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  logic       clk_div_q;
  logic       sync1_q;
  logic       sync2_q;
  logic       ped_pend_q;
  logic       ped_pend_d;
  logic [2:0] state_q;
  logic [2:0] state_d;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic [7:0] last;
  logic [2:0] nxt;

  // clk_div_q resets high so a divider already high gives no tick
  assign tick = clk_div & ~clk_div_q;

  // Edge detector and two-flop ped_req synchronizer
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      clk_div_q <= 1'b1;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
    end else begin
      clk_div_q <= clk_div;
      sync1_q   <= ped_req;
      sync2_q   <= sync1_q;
    end
  end

  // Per-state dwell limit and successor
  always_comb begin
    last = A_LAST;
    nxt  = S_AR2;
    unique case (state_q)
      S_MG:   begin last = G_LAST; nxt = S_MY;  end
      S_MY:   begin last = Y_LAST; nxt = S_AR1; end
      S_AR1:  begin last = A_LAST; nxt = S_SG;  end
      S_SG:   begin last = G_LAST; nxt = S_SY;  end
      S_SY:   begin last = Y_LAST; nxt = S_AR2; end
      S_AR2:  begin
        last = A_LAST;
        nxt  = ped_pend_q ? S_WALK : S_MG;
      end
      S_WALK: begin last = W_LAST; nxt = S_MG;  end
      default: begin last = A_LAST; nxt = S_AR2; end
    endcase
  end

  // Next state, dwell counter and pending-request update
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ped_pend_d = ped_pend_q;
    if (state_q == 3'd7) begin
      state_d = S_AR2;
      cnt_d   = 8'd0;
    end else if (tick) begin
      if (cnt_q == last) begin
        state_d = nxt;
        cnt_d   = 8'd0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
    if (state_q != S_WALK && state_d == S_WALK) begin
      ped_pend_d = 1'b0;
    end else if (sync2_q && state_q != S_WALK) begin
      ped_pend_d = 1'b1;
    end
  end

  // State, counter and pending-request registers
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      state_q    <= S_AR2;
      cnt_q      <= 8'd0;
      ped_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ped_pend_q <= ped_pend_d;
    end
  end

  // Moore lamp decode; unknown codes show all red
  always_comb begin
    main_light = RED;
    side_light = RED;
    walk       = 1'b0;
    unique case (state_q)
      S_MG:   main_light = GRN;
      S_MY:   main_light = YEL;
      S_AR1:  ;
      S_SG:   side_light = GRN;
      S_SY:   side_light = YEL;
      S_AR2:  ;
      S_WALK: walk = 1'b1;
      default: ;
    endcase
  end

  assign state    = state_q;
  assign ped_pend = ped_pend_q;

endmodule

// File: doc/traffic_light_fsm.md
# traffic_light_fsm

Intersection controller that consumes the slow `clk_div` square wave produced by the clock divider and steps a Moore state machine once per `clk_div` period. It drives main-road and side-road lamps plus a pedestrian walk lamp, with a latched pedestrian request. It runs entirely in the system `clk` domain: `clk_div` is edge-detected and used as an enable, never as a clock.

## Interface
- `GREEN_TICKS`, default 5, dwell of each green state in ticks (1..255)
- `YELLOW_TICKS`, default 2, dwell of each yellow state in ticks (1..255)
- `ALLRED_TICKS`, default 1, dwell of each all-red state in ticks (1..255)
- `WALK_TICKS`, default 4, dwell of walk state in ticks (1..255)

Ports:
- `clk`  in  1  system clock
- `rst_a`  in  1  reset, asynchronous, active-high
- `clk_div`  in  1  divider output, synchronous to `clk`
- `ped_req`  in  1  pedestrian button, asynchronous level
- `main_light`  out  3  {red, yellow, green} for main road, one-hot
- `side_light`  out  3  {red, yellow, green} for side road, one-hot
- `walk`  out  1  pedestrian walk lamp
- `state`  out  3  current state code
- `tick`  out  1  one-`clk` pulse per `clk_div` rising edge (debug)
- `ped_pend`  out  1  latched pedestrian request

## Operation
Tick generation:
- `clk_div_q` is `clk_div` delayed one `clk`; `tick = clk_div & ~clk_div_q`.
- `clk_div_q` resets to 1, so no spurious tick after reset.

Pedestrian request:
- `ped_req` passes through a 2-flop synchronizer, reset 0.
- `ped_pend` sets when the synchronized request is 1 and state ≠ WALK.
- Requests during WALK are ignored.
- `ped_pend` clears on the edge that enters WALK.

States (code: main/side/walk):
- MG 0: green/red/0
- MY 1: yellow/red/0
- AR1 2: red/red/0
- SG 3: red/green/0
- SY 4: red/yellow/0
- AR2 5: red/red/0
- WALK 6: red/red/1

Transitions, taken only on an edge where `tick`=1 and the dwell counter equals DUR-1:
- MG→MY (DUR = GREEN_TICKS)
- MY→AR1 (YELLOW_TICKS)
- AR1→SG (ALLRED_TICKS)
- SG→SY (GREEN_TICKS)
- SY→AR2 (YELLOW_TICKS)
- AR2→WALK if `ped_pend`=1, else AR2→MG (ALLRED_TICKS)
- WALK→MG (WALK_TICKS)

Dwell counter:
- 8 bits, zeroed on every transition.
- Increments on each non-expiring tick.
- Each state therefore lasts exactly DUR ticks.

Other rules:
- Illegal state code 7: on the next `clk` edge, force AR2 with counter 0, without waiting for a tick.
- Outputs are a combinational decode of the state register. Both roads are never non-red simultaneously.

## Timing
Reset values:
- state = AR2 (5), counter 0, `ped_pend` 0, `tick` 0, synchronizer flops 0
- `main_light` = `side_light` = 3'b100, `walk` 0

Latencies:
- `clk_div` rise to `tick`: `tick` is high in the first `clk` cycle where `clk_div`=1. The state update happens on the following edge, i.e. 1 `clk` after `clk_div` is seen high.
- `ped_req` rise to `ped_pend`=1: 3 `clk` edges (2 synchronizer edges, then the pending flop). A `ped_req` pulse of 2 or more `clk` cycles is guaranteed to be captured.

Boundary cases:
- Request sets `ped_pend` on the same edge AR2 expires: the decision uses the old `ped_pend`=0, so the FSM goes to MG. `ped_pend` stays 1 and is served at the next AR2.
- `rst_a` mid-state: everything returns to reset values immediately, without waiting for a `clk` edge. After release, the first tick counts toward AR2.
- `clk_div` stuck high or low: no ticks, so state and counter hold.

## Test plan
Bench parameters: GREEN=3, YELLOW=1, ALLRED=1, WALK=2. Bench toggles `clk_div` every 4 `clk` (one tick per 8 `clk`).

1. Reset, then free-run 20 ticks with no requests → state sequence 5,0,0,0,1,2,3,3,3,4,5,0,… with dwells 1/3/1/1/3/1/1. Lamps match the state table. `walk` never 1.
2. Pulse `ped_req` for 2 `clk` during SG → `ped_pend`=1 3 edges later. AR2 exits to WALK (`walk`=1 for 2 ticks, `ped_pend` cleared on entry), then MG.
3. `ped_req` held high through WALK → `ped_pend` stays 0 during WALK. It sets on the first cycle after WALK→MG.
4. Time the synchronized request to arrive on the AR2 expiry edge → next state MG, `ped_pend`=1. The following AR2 goes to WALK.
5. Assert `rst_a` mid-MG (counter 1) with `clk_div`=1 → immediately state 5, lamps 100/100. No tick on the first cycle after release.
6. Force the state register to 7 → AR2 on the next `clk` edge with no tick present. Also hold `clk_div` constant for 100 `clk` → state unchanged.
